// File: rtl/snake_pkg.sv
//------------------------------------------------------------------------------
// snake_pkg
// Shared encodings for the snake game engine: cell read codes, direction codes
// and the controller state enumeration.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package snake_pkg;

   // Cell read codes returned on rd_cell
   localparam logic [1:0] CELL_EMPTY = 2'd0;
   localparam logic [1:0] CELL_BODY  = 2'd1;
   localparam logic [1:0] CELL_HEAD  = 2'd2;
   localparam logic [1:0] CELL_APPLE = 2'd3;

   // Direction codes; opposite directions differ only in bit 1
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_RUN   = 3'd2,
      S_PLACE = 3'd3,
      S_DEAD  = 3'd4,
      S_WIN   = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/snake_body_fifo.sv
//------------------------------------------------------------------------------
// snake_body_fifo
// Circular buffer of (x,y) body segments. The head is the most recently pushed
// entry, the tail the oldest. Push and pop may happen in the same cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr_i               empty the buffer (new game)
//   push_i/push_x_i/_y_i append a new head segment
//   pop_i               drop the tail segment
//   head_x_o/head_y_o   newest segment (undefined while count_o == 0)
//   tail_x_o/tail_y_o   oldest segment (undefined while count_o == 0)
//   count_o             number of stored segments
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module snake_body_fifo
   import snake_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int XB      = 4,
   parameter int YB      = 4,
   parameter int LB      = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          push_i,
   input  logic [XB-1:0] push_x_i,
   input  logic [YB-1:0] push_y_i,
   input  logic          pop_i,
   output logic [XB-1:0] head_x_o,
   output logic [YB-1:0] head_y_o,
   output logic [XB-1:0] tail_x_o,
   output logic [YB-1:0] tail_y_o,
   output logic [LB-1:0] count_o
);

   localparam int PB = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [PB-1:0] PTR_LAST = PB'(MAX_LEN - 1);

   logic [XB+YB-1:0] mem_q [MAX_LEN];
   logic [PB-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PB-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PB-1:0]    hd_ptr_q, hd_ptr_d;
   logic [LB-1:0]    count_q, count_d;

   function automatic logic [PB-1:0] ptr_inc(input logic [PB-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PB'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      hd_ptr_d = hd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         hd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            hd_ptr_d = wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push_i && !pop_i) begin
            count_d = count_q + LB'(1);
         end else if (!push_i && pop_i) begin
            count_d = count_q - LB'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         hd_ptr_q <= hd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once count covers them.
   // On a full push+pop the write lands on the slot being popped.
   always_ff @(posedge clk) begin
      if (push_i && !clr_i) begin
         mem_q[wr_ptr_q] <= {push_x_i, push_y_i};
      end
   end

   assign {head_x_o, head_y_o} = mem_q[hd_ptr_q];
   assign {tail_x_o, tail_y_o} = mem_q[rd_ptr_q];
   assign count_o              = count_q;

endmodule

`default_nettype wire

// File: rtl/snake_engine.sv
//------------------------------------------------------------------------------
// snake_engine
// Snake game core: body buffer plus occupancy bitmap, move/collision/apple
// logic and a linear apple-placement scan.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a new game (wins over step)
//   step, dir                 move request and direction (0 up,1 right,2 down,3 left)
//   seed                      linear start index for the apple scan
//   rd_x, rd_y -> rd_cell     combinational cell query (0 empty,1 body,2 head,3 apple)
//   head_x/head_y, apple_x/apple_y, length, score
//   alive, busy, step_done, won  game status
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module snake_engine
   import snake_pkg::*;
#(
   parameter int SIZE_X   = 10,
   parameter int SIZE_Y   = 10,
   parameter int MAX_LEN  = 32,
   parameter int INIT_LEN = 4,
   parameter int WRAP     = 0,
   localparam int XB = $clog2(SIZE_X),
   localparam int YB = $clog2(SIZE_Y),
   localparam int NB = $clog2(SIZE_X * SIZE_Y),
   localparam int LB = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          step,
   input  logic [1:0]    dir,
   input  logic [NB-1:0] seed,
   input  logic [XB-1:0] rd_x,
   input  logic [YB-1:0] rd_y,
   output logic [1:0]    rd_cell,
   output logic [XB-1:0] head_x,
   output logic [YB-1:0] head_y,
   output logic [XB-1:0] apple_x,
   output logic [YB-1:0] apple_y,
   output logic [LB-1:0] length,
   output logic [15:0]   score,
   output logic          alive,
   output logic          busy,
   output logic          step_done,
   output logic          won
);

   localparam int N = SIZE_X * SIZE_Y;
   localparam logic [XB-1:0] X_MAX     = XB'(SIZE_X - 1);
   localparam logic [YB-1:0] Y_MAX     = YB'(SIZE_Y - 1);
   localparam logic [NB-1:0] IDX_LAST  = NB'(N - 1);
   localparam logic [LB-1:0] LEN_FULL  = LB'(MAX_LEN);
   localparam logic [LB-1:0] INIT_LAST = LB'(INIT_LEN - 1);

   function automatic logic [NB-1:0] lin(input logic [XB-1:0] x, input logic [YB-1:0] y);
      return NB'(int'(y) * SIZE_X + int'(x));
   endfunction

   state_t        state_q, state_d;
   logic [1:0]    dir_q, dir_d;
   logic [LB-1:0] init_cnt_q, init_cnt_d;
   logic [NB-1:0] scan_idx_q, scan_idx_d;
   logic [NB-1:0] scan_cnt_q, scan_cnt_d;
   logic [XB-1:0] apple_x_q, apple_x_d;
   logic [YB-1:0] apple_y_q, apple_y_d;
   logic          apple_vld_q, apple_vld_d;
   logic [15:0]   score_q, score_d;
   logic          alive_q, alive_d;
   logic          won_q, won_d;
   logic          step_done_q, step_done_d;
   logic [N-1:0]  occ_q, occ_d;

   // Body buffer
   logic          fifo_clr, fifo_push, fifo_pop;
   logic [XB-1:0] push_x, fifo_head_x, tail_x;
   logic [YB-1:0] push_y, fifo_head_y, tail_y;
   logic [LB-1:0] count;

   snake_body_fifo #(
      .MAX_LEN (MAX_LEN),
      .XB      (XB),
      .YB      (YB),
      .LB      (LB)
   ) u_body (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (fifo_clr),
      .push_i   (fifo_push),
      .push_x_i (push_x),
      .push_y_i (push_y),
      .pop_i    (fifo_pop),
      .head_x_o (fifo_head_x),
      .head_y_o (fifo_head_y),
      .tail_x_o (tail_x),
      .tail_y_o (tail_y),
      .count_o  (count)
   );

   // An empty body reports the head at the origin so reset outputs are zero
   assign head_x = (count != '0) ? fifo_head_x : '0;
   assign head_y = (count != '0) ? fifo_head_y : '0;

   // Move target evaluation
   logic [1:0]    new_dir;
   logic [XB-1:0] tx;
   logic [YB-1:0] ty;
   logic          wall;
   logic [NB-1:0] tidx, tail_idx, seed_start;
   logic          eat, grow, hit;

   always_comb begin
      // A 180-degree reversal flips only bit 1 of the direction code
      new_dir = (dir == (dir_q ^ 2'd2)) ? dir_q : dir;
      tx      = head_x;
      ty      = head_y;
      wall    = 1'b0;
      case (new_dir)
         DIR_UP: begin
            if (head_y == '0) begin
               wall = (WRAP == 0);
               ty   = Y_MAX;
            end else begin
               ty = head_y - YB'(1);
            end
         end
         DIR_RIGHT: begin
            if (head_x == X_MAX) begin
               wall = (WRAP == 0);
               tx   = '0;
            end else begin
               tx = head_x + XB'(1);
            end
         end
         DIR_DOWN: begin
            if (head_y == Y_MAX) begin
               wall = (WRAP == 0);
               ty   = '0;
            end else begin
               ty = head_y + YB'(1);
            end
         end
         default: begin
            if (head_x == '0) begin
               wall = (WRAP == 0);
               tx   = X_MAX;
            end else begin
               tx = head_x - XB'(1);
            end
         end
      endcase
   end

   assign tidx       = lin(tx, ty);
   assign tail_idx   = lin(tail_x, tail_y);
   assign eat        = apple_vld_q && (tx == apple_x_q) && (ty == apple_y_q);
   assign grow       = eat && (count != LEN_FULL);
   // The tail cell is vacated in the same move unless the body grows
   assign hit        = occ_q[tidx] && !(!grow && (tidx == tail_idx));
   assign seed_start = (seed <= IDX_LAST) ? seed : '0;

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      init_cnt_d  = init_cnt_q;
      scan_idx_d  = scan_idx_q;
      scan_cnt_d  = scan_cnt_q;
      apple_x_d   = apple_x_q;
      apple_y_d   = apple_y_q;
      apple_vld_d = apple_vld_q;
      score_d     = score_q;
      alive_d     = alive_q;
      won_d       = won_q;
      step_done_d = 1'b0;
      occ_d       = occ_q;
      fifo_clr    = 1'b0;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      push_x      = '0;
      push_y      = '0;

      if (start) begin
         state_d     = S_INIT;
         dir_d       = DIR_RIGHT;
         init_cnt_d  = '0;
         apple_x_d   = '0;
         apple_y_d   = '0;
         apple_vld_d = 1'b0;
         score_d     = '0;
         alive_d     = 1'b1;
         won_d       = 1'b0;
         occ_d       = '0;
         fifo_clr    = 1'b1;
      end else begin
         case (state_q)
            S_INIT: begin
               push_x    = XB'(init_cnt_q) + XB'(1);
               push_y    = YB'(1);
               fifo_push = 1'b1;
               occ_d[lin(push_x, push_y)] = 1'b1;
               if (init_cnt_q == INIT_LAST) begin
                  state_d    = S_PLACE;
                  scan_idx_d = seed_start;
                  scan_cnt_d = '0;
               end else begin
                  init_cnt_d = init_cnt_q + LB'(1);
               end
            end
            S_PLACE: begin
               if (!occ_q[scan_idx_q]) begin
                  apple_x_d   = XB'(scan_idx_q % SIZE_X);
                  apple_y_d   = YB'(scan_idx_q / SIZE_X);
                  apple_vld_d = 1'b1;
                  state_d     = S_RUN;
                  step_done_d = 1'b1;
               end else if (scan_cnt_q == IDX_LAST) begin
                  won_d   = 1'b1;
                  alive_d = 1'b0;
                  state_d = S_WIN;
               end else begin
                  scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + NB'(1);
                  scan_cnt_d = scan_cnt_q + NB'(1);
               end
            end
            S_RUN: begin
               if (step) begin
                  if (wall || hit) begin
                     alive_d = 1'b0;
                     state_d = S_DEAD;
                  end else begin
                     dir_d     = new_dir;
                     fifo_push = 1'b1;
                     push_x    = tx;
                     push_y    = ty;
                     fifo_pop  = !grow;
                     // Clear before set so a head entering the old tail cell stays marked
                     if (!grow) begin
                        occ_d[tail_idx] = 1'b0;
                     end
                     occ_d[tidx] = 1'b1;
                     if (eat) begin
                        if (score_q != 16'hFFFF) begin
                           score_d = score_q + 16'd1;
                        end
                        state_d    = S_PLACE;
                        scan_idx_d = seed_start;
                        scan_cnt_d = '0;
                     end else begin
                        step_done_d = 1'b1;
                     end
                  end
               end
            end
            S_IDLE, S_DEAD, S_WIN: begin
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         dir_q       <= '0;
         init_cnt_q  <= '0;
         scan_idx_q  <= '0;
         scan_cnt_q  <= '0;
         apple_x_q   <= '0;
         apple_y_q   <= '0;
         apple_vld_q <= 1'b0;
         score_q     <= '0;
         alive_q     <= 1'b0;
         won_q       <= 1'b0;
         step_done_q <= 1'b0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         init_cnt_q  <= init_cnt_d;
         scan_idx_q  <= scan_idx_d;
         scan_cnt_q  <= scan_cnt_d;
         apple_x_q   <= apple_x_d;
         apple_y_q   <= apple_y_d;
         apple_vld_q <= apple_vld_d;
         score_q     <= score_d;
         alive_q     <= alive_d;
         won_q       <= won_d;
         step_done_q <= step_done_d;
         occ_q       <= occ_d;
      end
   end

   // Cell query: head wins over body, body over apple
   always_comb begin
      rd_cell = CELL_EMPTY;
      if ((rd_x <= X_MAX) && (rd_y <= Y_MAX)) begin
         if ((count != '0) && (rd_x == head_x) && (rd_y == head_y)) begin
            rd_cell = CELL_HEAD;
         end else if (occ_q[lin(rd_x, rd_y)]) begin
            rd_cell = CELL_BODY;
         end else if (apple_vld_q && (rd_x == apple_x_q) && (rd_y == apple_y_q)) begin
            rd_cell = CELL_APPLE;
         end
      end
   end

   assign apple_x   = apple_x_q;
   assign apple_y   = apple_y_q;
   assign length    = count;
   assign score     = score_q;
   assign alive     = alive_q;
   assign busy      = (state_q != S_RUN);
   assign step_done = step_done_q;
   assign won       = won_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_engine.sv
//------------------------------------------------------------------------------
// tb_snake_engine
// Directed bench for snake_engine on a 10x10 field, INIT_LEN 4, MAX_LEN 32.
// Instance a has walls (WRAP=0), instance b wraps (WRAP=1); both share inputs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_snake_engine;

   localparam logic [1:0] UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3;

   logic       clk = 1'b0;
   logic       rst, start, step;
   logic [1:0] dir;
   logic [6:0] seed;
   logic [3:0] rd_x, rd_y;

   logic [1:0] a_rd_cell, b_rd_cell;
   logic [3:0] a_head_x, a_head_y, a_apple_x, a_apple_y;
   logic [3:0] b_head_x, b_head_y, b_apple_x, b_apple_y;
   logic [5:0] a_length, b_length;
   logic [15:0] a_score, b_score;
   logic a_alive, a_busy, a_step_done, a_won;
   logic b_alive, b_busy, b_step_done, b_won;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   snake_engine #(.SIZE_X(10), .SIZE_Y(10), .MAX_LEN(32), .INIT_LEN(4), .WRAP(0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .step(step), .dir(dir), .seed(seed),
      .rd_x(rd_x), .rd_y(rd_y), .rd_cell(a_rd_cell),
      .head_x(a_head_x), .head_y(a_head_y), .apple_x(a_apple_x), .apple_y(a_apple_y),
      .length(a_length), .score(a_score), .alive(a_alive), .busy(a_busy),
      .step_done(a_step_done), .won(a_won)
   );

   snake_engine #(.SIZE_X(10), .SIZE_Y(10), .MAX_LEN(32), .INIT_LEN(4), .WRAP(1)) dut_b (
      .clk(clk), .rst(rst), .start(start), .step(step), .dir(dir), .seed(seed),
      .rd_x(rd_x), .rd_y(rd_y), .rd_cell(b_rd_cell),
      .head_x(b_head_x), .head_y(b_head_y), .apple_x(b_apple_x), .apple_y(b_apple_y),
      .length(b_length), .score(b_score), .alive(b_alive), .busy(b_busy),
      .step_done(b_step_done), .won(b_won)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_step(input logic [1:0] d);
      dir  = d;
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   // Start a game and wait (bounded) for the apple-placed pulse
   task automatic start_game(input logic [6:0] s);
      int n;
      seed  = s;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!a_step_done && n < 50) begin
         tick();
         n++;
      end
      total++;
      if (a_step_done !== 1'b1) begin
         bad++;
         $display("FAIL start_timeout step_done=%0b exp=1", a_step_done);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; step = 1'b0; dir = UP; seed = '0; rd_x = '0; rd_y = '0;
      tick(); tick();
      rst = 1'b0;
      total++;
      if ({a_head_x, a_head_y, a_apple_x, a_apple_y} !== 16'h0) begin
         bad++; $display("FAIL reset_pos got=%h exp=0", {a_head_x, a_head_y, a_apple_x, a_apple_y});
      end
      total++;
      if ({a_length, a_score} !== 22'h0) begin
         bad++; $display("FAIL reset_len_score got=%0d/%0d exp=0/0", a_length, a_score);
      end
      total++;
      if ({a_alive, a_busy, a_step_done, a_won, a_rd_cell} !== 6'b010000) begin
         bad++; $display("FAIL reset_flags got=%b exp=010000", {a_alive, a_busy, a_step_done, a_won, a_rd_cell});
      end
   endtask

   // Exact timing: start edge, 4 INIT edges, 1 PLACE edge
   task automatic test_init;
      seed  = 7'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({a_busy, a_length} !== {1'b1, 6'd0}) begin
         bad++; $display("FAIL init_entry busy/len got=%0b/%0d exp=1/0", a_busy, a_length);
      end
      repeat (4) tick();
      total++;
      if ({a_busy, a_step_done, a_length} !== {1'b1, 1'b0, 6'd4}) begin
         bad++; $display("FAIL init_pushed busy/done/len got=%0b/%0b/%0d exp=1/0/4", a_busy, a_step_done, a_length);
      end
      tick();
      total++;
      if ({a_step_done, a_busy, a_alive} !== 3'b101) begin
         bad++; $display("FAIL init_done done/busy/alive got=%b exp=101", {a_step_done, a_busy, a_alive});
      end
      total++;
      if ({a_head_x, a_head_y, a_length} !== {4'd4, 4'd1, 6'd4}) begin
         bad++; $display("FAIL init_head got=(%0d,%0d) len=%0d exp=(4,1) len=4", a_head_x, a_head_y, a_length);
      end
      total++;
      if ({a_apple_x, a_apple_y} !== {4'd0, 4'd0}) begin
         bad++; $display("FAIL init_apple got=(%0d,%0d) exp=(0,0)", a_apple_x, a_apple_y);
      end
      rd_x = 4'd4; rd_y = 4'd1; #1;
      total++;
      if (a_rd_cell !== 2'd2) begin bad++; $display("FAIL rd_head got=%0d exp=2", a_rd_cell); end
      rd_x = 4'd2; rd_y = 4'd1; #1;
      total++;
      if (a_rd_cell !== 2'd1) begin bad++; $display("FAIL rd_body got=%0d exp=1", a_rd_cell); end
      rd_x = 4'd0; rd_y = 4'd0; #1;
      total++;
      if (a_rd_cell !== 2'd3) begin bad++; $display("FAIL rd_apple got=%0d exp=3", a_rd_cell); end
      rd_x = 4'd5; rd_y = 4'd5; #1;
      total++;
      if (a_rd_cell !== 2'd0) begin bad++; $display("FAIL rd_empty got=%0d exp=0", a_rd_cell); end
      tick();
      total++;
      if (a_step_done !== 1'b0) begin bad++; $display("FAIL init_pulse_width got=%0b exp=0", a_step_done); end
   endtask

   task automatic test_wall;
      start_game(7'd0);
      repeat (5) do_step(RIGHT);
      total++;
      if ({a_head_x, a_head_y, b_head_x, b_head_y} !== {4'd9, 4'd1, 4'd9, 4'd1}) begin
         bad++; $display("FAIL wall_five a=(%0d,%0d) b=(%0d,%0d) exp=(9,1)", a_head_x, a_head_y, b_head_x, b_head_y);
      end
      do_step(RIGHT);
      total++;
      if ({a_alive, a_busy, a_step_done, a_head_x, a_head_y} !== {3'b010, 4'd9, 4'd1}) begin
         bad++; $display("FAIL wall_dead alive/busy/done=%b head=(%0d,%0d) exp=010 (9,1)",
                         {a_alive, a_busy, a_step_done}, a_head_x, a_head_y);
      end
      total++;
      if ({b_alive, b_head_x, b_head_y, b_length} !== {1'b1, 4'd0, 4'd1, 6'd4}) begin
         bad++; $display("FAIL wrap_head alive=%0b head=(%0d,%0d) len=%0d exp=1 (0,1) 4", b_alive, b_head_x, b_head_y, b_length);
      end
      do_step(DOWN);
      total++;
      if ({a_head_x, a_head_y, a_length} !== {4'd9, 4'd1, 6'd4}) begin
         bad++; $display("FAIL dead_ignores_step head=(%0d,%0d) len=%0d exp=(9,1) 4", a_head_x, a_head_y, a_length);
      end
   endtask

   task automatic test_reverse;
      start_game(7'd0);
      do_step(LEFT);
      total++;
      if ({a_head_x, a_head_y, a_alive, a_step_done} !== {4'd5, 4'd1, 2'b11}) begin
         bad++; $display("FAIL reverse head=(%0d,%0d) alive/done=%b exp=(5,1) 11", a_head_x, a_head_y, {a_alive, a_step_done});
      end
   endtask

   task automatic test_eat;
      start_game(7'd15);
      total++;
      if ({a_apple_x, a_apple_y} !== {4'd5, 4'd1}) begin
         bad++; $display("FAIL eat_apple0 got=(%0d,%0d) exp=(5,1)", a_apple_x, a_apple_y);
      end
      do_step(RIGHT);
      total++;
      if ({a_head_x, a_head_y, a_length, a_score} !== {4'd5, 4'd1, 6'd5, 16'd1}) begin
         bad++; $display("FAIL eat_grow head=(%0d,%0d) len=%0d score=%0d exp=(5,1) 5 1", a_head_x, a_head_y, a_length, a_score);
      end
      total++;
      if ({a_busy, a_step_done} !== 2'b10) begin
         bad++; $display("FAIL eat_place busy/done got=%b exp=10", {a_busy, a_step_done});
      end
      do_step(DOWN);
      total++;
      if ({a_busy, a_head_x, a_head_y} !== {1'b1, 4'd5, 4'd1}) begin
         bad++; $display("FAIL busy_step_ignored busy=%0b head=(%0d,%0d) exp=1 (5,1)", a_busy, a_head_x, a_head_y);
      end
      tick();
      total++;
      if ({a_step_done, a_busy, a_apple_x, a_apple_y} !== {2'b10, 4'd6, 4'd1}) begin
         bad++; $display("FAIL eat_apple1 done/busy=%b apple=(%0d,%0d) exp=10 (6,1)", {a_step_done, a_busy}, a_apple_x, a_apple_y);
      end
   endtask

   task automatic test_self_collision;
      do_step(DOWN);
      do_step(LEFT);
      total++;
      if ({a_head_x, a_head_y, a_alive} !== {4'd4, 4'd2, 1'b1}) begin
         bad++; $display("FAIL coll_path head=(%0d,%0d) alive=%0b exp=(4,2) 1", a_head_x, a_head_y, a_alive);
      end
      do_step(UP);
      total++;
      if ({a_alive, a_busy, a_head_x, a_head_y, a_length, a_score} !== {2'b01, 4'd4, 4'd2, 6'd5, 16'd1}) begin
         bad++; $display("FAIL coll_dead alive=%0b busy=%0b head=(%0d,%0d) len=%0d score=%0d exp=0 1 (4,2) 5 1",
                         a_alive, a_busy, a_head_x, a_head_y, a_length, a_score);
      end
   endtask

   task automatic test_loop;
      logic [1:0] pat [4];
      int lost;
      pat[0] = UP; pat[1] = RIGHT; pat[2] = DOWN; pat[3] = LEFT;
      start_game(7'd0);
      do_step(DOWN);
      do_step(LEFT);
      lost = 0;
      for (int i = 0; i < 8; i++) begin
         do_step(pat[i % 4]);
         if (a_alive !== 1'b1 || a_step_done !== 1'b1) lost++;
      end
      total++;
      if (lost !== 0) begin bad++; $display("FAIL loop_alive lost_steps=%0d exp=0", lost); end
      total++;
      if ({a_head_x, a_head_y, a_length} !== {4'd3, 4'd2, 6'd4}) begin
         bad++; $display("FAIL loop_head head=(%0d,%0d) len=%0d exp=(3,2) 4", a_head_x, a_head_y, a_length);
      end
      test_init();
   endtask

   task automatic test_start_priority;
      seed  = 7'd0;
      dir   = RIGHT;
      start = 1'b1;
      step  = 1'b1;
      tick();
      start = 1'b0;
      step  = 1'b0;
      total++;
      if ({a_busy, a_length} !== {1'b1, 6'd0}) begin
         bad++; $display("FAIL start_priority busy=%0b len=%0d exp=1 0", a_busy, a_length);
      end
      repeat (5) tick();
      total++;
      if ({a_head_x, a_head_y, a_busy} !== {4'd4, 4'd1, 1'b0}) begin
         bad++; $display("FAIL start_priority_head head=(%0d,%0d) busy=%0b exp=(4,1) 0", a_head_x, a_head_y, a_busy);
      end
   endtask

   task automatic test_rst_mid_init;
      seed  = 7'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      total++;
      if ({a_length, a_head_x, a_head_y} !== {6'd2, 4'd2, 4'd1}) begin
         bad++; $display("FAIL mid_init len=%0d head=(%0d,%0d) exp=2 (2,1)", a_length, a_head_x, a_head_y);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      total++;
      if ({a_length, a_head_x, a_head_y, a_score, a_alive, a_busy, a_step_done} !== {6'd0, 8'd0, 16'd0, 3'b010}) begin
         bad++; $display("FAIL rst_abort len=%0d head=(%0d,%0d) alive/busy/done=%b exp=0 (0,0) 010",
                         a_length, a_head_x, a_head_y, {a_alive, a_busy, a_step_done});
      end
      do_step(RIGHT);
      total++;
      if ({a_busy, a_length} !== {1'b1, 6'd0}) begin
         bad++; $display("FAIL idle_ignores_step busy=%0b len=%0d exp=1 0", a_busy, a_length);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_init();
      test_wall();
      test_reverse();
      test_eat();
      test_self_collision();
      test_loop();
      test_start_priority();
      test_rst_mid_init();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
